// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with HI/LO result registers
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_md;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_is_md  = (op[2] == 1'b0);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_sign_a = w_signed & opA[WIDTH-1];
    assign w_sign_b = w_signed & opB[WIDTH-1];
    // Negating INT_MIN wraps back to 2^(WIDTH-1), which is exactly its unsigned magnitude.
    assign w_abs_a  = w_sign_a ? (~opA + 1'b1) : opA;
    assign w_abs_b  = w_sign_b ? (~opB + 1'b1) : opB;

    // Multiply: upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
    assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_acc[WIDTH-1:0];
    assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            // A zero divisor leaves remainder = |opA|, so the dividend sign restores opA.
            w_fix_hi = r_neg_a ? (~w_rem + 1'b1) : w_rem;
            if (r_opnd == '0)
                w_fix_lo = '1;
            else
                w_fix_lo = (r_neg_a ^ r_neg_b) ? (~w_quo + 1'b1) : w_quo;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_md) begin
                            r_state  <= S_RUN;
                            r_cnt    <= '0;
                            r_is_div <= op[1];
                            r_neg_a  <= w_sign_a;
                            r_neg_b  <= w_sign_b;
                            if (op[1]) begin
                                r_opnd <= w_abs_b;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            end else begin
                                r_opnd <= w_abs_a;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            end
                        end else if (op == OP_MTHI) begin
                            r_hi <= opA;
                        end else if (op == OP_MTLO) begin
                            r_lo <= opA;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH-1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] opA, opB;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8, flush8;
    logic [2:0]  op8;
    logic [7:0]  opA8, opB8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rstN(rstN), .start(start), .op(op), .opA(opA), .opB(opB),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstN(rstN), .start(start8), .op(op8), .opA(opA8), .opB(opB8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        opA   = 32'hDEAD_BEEF;
        opB   = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] eh, input logic [31:0] el);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
    endtask

    task automatic wait_done8(input string tag, input logic [7:0] eh, input logic [7:0] el);
        int n;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 9);
        check({tag, " hi"}, hi8, eh);
        check({tag, " lo"}, lo8, el);
    endtask

    initial begin
        int seen;
        rstN = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opA = '0; opB = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = '0; opA8 = '0; opB8 = '0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        issue(MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult busy", busy, 1'b1);
        wait_done("mult", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        check("b2b busy", busy, 1'b1);
        check("b2b done drop", done, 1'b0);
        wait_done("multu", 33, 32'h0000_0001, 32'hFFFF_FFFE);

        issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(DIV, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_done("div 7/-2", 33, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(DIVU, 32'h0000_0007, 32'h0000_0002);
        wait_done("divu 7/2", 33, 32'h0000_0001, 32'h0000_0003);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div ovf", 33, 32'h0000_0000, 32'h8000_0000);
        issue(DIVU, 32'h0000_1234, 32'h0000_0000);
        wait_done("divu by0", 33, 32'h0000_1234, 32'hFFFF_FFFF);
        issue(DIV, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_done("div by0", 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        issue(MULT, 32'h0000_0003, 32'h0000_0005);
        repeat (4) @(posedge clk);
        issue(MTHI, 32'h0000_AAAA, 32'h0);
        check("busy mthi hi", hi, 32'hFFFF_FFF9);
        check("busy mthi busy", busy, 1'b1);
        wait_done("mult ign", 28, 32'h0000_0000, 32'h0000_000F);

        issue(MTHI, 32'h0000_1111, 32'h0);
        check("mthi hi", hi, 32'h0000_1111);
        check("mthi done", done, 1'b0);
        issue(MTLO, 32'h0000_2222, 32'h0);
        check("mtlo lo", lo, 32'h0000_2222);
        check("mtlo busy", busy, 1'b0);
        issue(3'b110, 32'h0000_9999, 32'h0);
        check("undef hi", hi, 32'h0000_1111);
        check("undef lo", lo, 32'h0000_2222);
        check("undef busy", busy, 1'b0);

        issue(MULT, 32'h0000_0007, 32'h0000_0009);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", busy, 1'b0);
        check("flush done", done, 1'b0);
        check("flush hi", hi, 32'h0000_1111);
        check("flush lo", lo, 32'h0000_2222);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("flush no done", seen, 0);

        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = MULTU; opA = 32'd3; opB = 32'd4;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        check("idle flush start busy", busy, 1'b1);
        wait_done("idle flush multu", 33, 32'h0, 32'h0000_000C);

        issue(MTHI, 32'h0000_0077, 32'h0);
        issue(DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rstN = 1'b0;
        #1;
        check("async rst busy", busy, 1'b0);
        check("async rst done", done, 1'b0);
        check("async rst hi", hi, 32'h0);
        check("async rst lo", lo, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        issue(MTLO, 32'h0000_0005, 32'h0);
        check("post rst mtlo lo", lo, 32'h0000_0005);
        check("post rst mtlo done", done, 1'b0);
        issue(DIVU, 32'd100, 32'd7);
        wait_done("post rst divu", 33, 32'h0000_0002, 32'h0000_000E);

        @(negedge clk);
        start8 = 1'b1; op8 = MULT; opA8 = 8'h80; opB8 = 8'h80;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("w8 busy", busy8, 1'b1);
        wait_done8("w8 mult", 8'h40, 8'h00);
        @(negedge clk);
        start8 = 1'b1; op8 = DIV; opA8 = 8'h80; opB8 = 8'hFF;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8("w8 div ovf", 8'h00, 8'h80);
        @(negedge clk);
        start8 = 1'b1; op8 = DIV; opA8 = 8'hF9; opB8 = 8'h02;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8("w8 div", 8'hFF, 8'hFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
